// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - synchronous 32x8 memory responder with clear sweep, access counters and error flags
//
// Purpose: target end of a read/write strobe memory bus. After reset it sweeps
// every word to zero (busy high), then executes single-strobe reads and writes.
// A read returns data one cycle later on data_out. Reads and writes are counted
// with saturating 8-bit counters. Any strobe during the sweep, or both strobes
// at once, sets the sticky rw_err flag.
//
// Optional feature macro: MEM_PARITY_EN (per-word even parity, par_inject, par_err).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   read       in   read strobe
//   write      in   write strobe
//   addr       in   [AWIDTH-1:0] word address
//   data_in    in   [DWIDTH-1:0] write data
//   par_inject in   store inverted parity on an executed write (parity build only)
//   data_out   out  [DWIDTH-1:0] registered read data
//   busy       out  high while the clear sweep runs
//   rw_err     out  sticky protocol-violation flag
//   rd_cnt     out  [7:0] saturating executed-read count
//   wr_cnt     out  [7:0] saturating executed-write count
//   par_err    out  parity mismatch on the data presented this cycle

module mem_responder #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              par_inject,
  output logic [DWIDTH-1:0] data_out,
  output logic              busy,
  output logic              rw_err,
  output logic [7:0]        rd_cnt,
  output logic [7:0]        wr_cnt,
  output logic              par_err
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [AWIDTH-1:0] r_ptr;
  logic [AWIDTH-1:0] w_ptr_nx;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_data_out;
  logic              r_rw_err;
  logic [7:0]        r_rd_cnt;
  logic [7:0]        r_wr_cnt;

  logic              w_we;
  logic [AWIDTH-1:0] w_waddr;
  logic [DWIDTH-1:0] w_wdata;
  logic              w_wr_exec;
  logic              w_rd_exec;
  logic              w_err_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_we       = 1'b0;
    w_waddr    = addr;
    w_wdata    = data_in;
    w_wr_exec  = 1'b0;
    w_rd_exec  = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      INIT: begin
        // Sweep owns the write port; bus strobes are rejected and flagged.
        w_we     = 1'b1;
        w_waddr  = r_ptr;
        w_wdata  = '0;
        w_ptr_nx = r_ptr + 1'b1;
        if (r_ptr == LAST_ADDR) w_state_nx = READY;
        if (read || write) w_err_set = 1'b1;
      end
      READY: begin
        if (read && write) begin
          w_err_set = 1'b1;
        end else if (write) begin
          w_we      = 1'b1;
          w_wr_exec = 1'b1;
        end else if (read) begin
          w_rd_exec = 1'b1;
        end
      end
      default: w_state_nx = INIT;
    endcase
  end

  // Storage is not reset; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!rst && w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
      r_rw_err   <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      if (w_rd_exec) r_data_out <= r_mem[addr];
      if (w_err_set) r_rw_err <= 1'b1;
      if (w_rd_exec && r_rd_cnt != 8'hFF) r_rd_cnt <= r_rd_cnt + 8'd1;
      if (w_wr_exec && r_wr_cnt != 8'hFF) r_wr_cnt <= r_wr_cnt + 8'd1;
    end
  end

`ifdef MEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_par_err;

  // Sweep writes zero with correct parity; injection only applies to bus writes.
  always_ff @(posedge clk) begin
    if (!rst && w_we) r_par[w_waddr] <= (^w_wdata) ^ (w_wr_exec & par_inject);
  end

  // Pulses only in the cycle after an executed read.
  always_ff @(posedge clk) begin
    if (rst) r_par_err <= 1'b0;
    else     r_par_err <= w_rd_exec && ((^r_mem[addr]) != r_par[addr]);
  end

  assign par_err = r_par_err;
`else
  logic w_unused_par_inject;
  assign w_unused_par_inject = par_inject;
  assign par_err = 1'b0;
`endif

  assign data_out = r_data_out;
  assign busy     = (r_state == INIT);
  assign rw_err   = r_rw_err;
  assign rd_cnt   = r_rd_cnt;
  assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       par_inject = 1'b0;
  logic [7:0] data_out;
  logic       busy;
  logic       rw_err;
  logic [7:0] rd_cnt;
  logic [7:0] wr_cnt;
  logic       par_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MEM_PARITY_EN
  localparam logic PAR_EXP = 1'b1;
`else
  localparam logic PAR_EXP = 1'b0;
`endif

  mem_responder dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .par_inject(par_inject), .data_out(data_out),
    .busy(busy), .rw_err(rw_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .par_err(par_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d, input logic inj);
    addr = a; data_in = d; par_inject = inj; write = 1'b1;
    tick();
    write = 1'b0; par_inject = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    addr = a; read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic wait_sweep(input string name);
    int cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc !== 32) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d expected 32", name, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({busy, rw_err, par_err} !== 3'b100 || data_out !== 8'h00 || rd_cnt !== 8'd0 || wr_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%0b rw_err=%0b par_err=%0b data_out=%h rd=%0d wr=%0d expected 1 0 0 00 0 0",
               busy, rw_err, par_err, data_out, rd_cnt, wr_cnt);
    end
    wait_sweep("reset_sweep");
  endtask

  task automatic test_clear();
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i));
      n_tests++;
      if (data_out !== 8'h00) begin
        n_fail++;
        $display("FAIL clear_word[%0d]: got %h expected 00", i, data_out);
      end
    end
    n_tests++;
    if (rw_err !== 1'b0 || rd_cnt !== 8'd32) begin
      n_fail++;
      $display("FAIL clear_status: rw_err=%0b rd_cnt=%0d expected 0 32", rw_err, rd_cnt);
    end
  endtask

  task automatic test_data_eq_addr();
    for (int i = 0; i < 32; i++) do_write(5'(i), 8'(i), 1'b0);
    n_tests++;
    if (wr_cnt !== 8'd32) begin
      n_fail++;
      $display("FAIL addr_data_wr_cnt: got %0d expected 32", wr_cnt);
    end
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i));
      n_tests++;
      if (data_out !== 8'(i)) begin
        n_fail++;
        $display("FAIL addr_data[%0d]: got %h expected %h", i, data_out, 8'(i));
      end
    end
  endtask

  task automatic test_random_ascii();
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 9) < 8) v = 8'h41 + 8'($urandom_range(0, 25));
      else                          v = 8'h61 + 8'($urandom_range(0, 25));
      do_write(5'(i), v, 1'b0);
      do_read(5'(i));
      n_tests++;
      if (data_out !== v || par_err !== 1'b0) begin
        n_fail++;
        $display("FAIL ascii[%0d]: data=%h par_err=%0b expected %h 0", i, data_out, par_err, v);
      end
    end
    n_tests++;
    if (rd_cnt !== 8'd96 || wr_cnt !== 8'd64) begin
      n_fail++;
      $display("FAIL ascii_counts: rd=%0d wr=%0d expected 96 64", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_collision();
    do_write(5'd3, 8'hA5, 1'b0);
    do_read(5'd3);
    addr = 5'd3; data_in = 8'h5A; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    n_tests++;
    if (rw_err !== 1'b1 || data_out !== 8'hA5 || rd_cnt !== 8'd97 || wr_cnt !== 8'd65) begin
      n_fail++;
      $display("FAIL collision: rw_err=%0b data=%h rd=%0d wr=%0d expected 1 a5 97 65", rw_err, data_out, rd_cnt, wr_cnt);
    end
    tick(); tick();
    do_read(5'd3);
    n_tests++;
    if (rw_err !== 1'b1 || data_out !== 8'hA5 || rd_cnt !== 8'd98) begin
      n_fail++;
      $display("FAIL collision_after: rw_err=%0b data=%h rd=%0d expected 1 a5 98", rw_err, data_out, rd_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 195; i++) do_write(5'd20, 8'h7E, 1'b0);
    n_tests++;
    if (wr_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL wr_saturate: got %0d expected 255", wr_cnt);
    end
    for (int i = 0; i < 160; i++) do_read(5'd20);
    n_tests++;
    if (rd_cnt !== 8'd255 || data_out !== 8'h7E) begin
      n_fail++;
      $display("FAIL rd_saturate: rd=%0d data=%h expected 255 7e", rd_cnt, data_out);
    end
  endtask

  task automatic test_busy_midsweep();
    for (int i = 0; i < 32; i++) do_write(5'(i), 8'hC3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read = 1'b1; addr = 5'd9;
    tick();
    read = 1'b0;
    n_tests++;
    if (rw_err !== 1'b1 || rd_cnt !== 8'd0 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL busy_read: rw_err=%0b rd=%0d data=%h expected 1 0 00", rw_err, rd_cnt, data_out);
    end
    for (int i = 1; i < 17; i++) tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_at_ptr17: got %0b expected 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (rw_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midsweep_reset: rw_err=%0b busy=%0b expected 0 1", rw_err, busy);
    end
    wait_sweep("midsweep_sweep");
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i));
      n_tests++;
      if (data_out !== 8'h00) begin
        n_fail++;
        $display("FAIL midsweep_clear[%0d]: got %h expected 00", i, data_out);
      end
    end
  endtask

  task automatic test_parity();
    do_write(5'd7, 8'h41, 1'b1);
    do_read(5'd7);
    n_tests++;
    if (data_out !== 8'h41 || par_err !== PAR_EXP) begin
      n_fail++;
      $display("FAIL parity_inject: data=%h par_err=%0b expected 41 %0b", data_out, par_err, PAR_EXP);
    end
    tick();
    n_tests++;
    if (par_err !== 1'b0 || data_out !== 8'h41) begin
      n_fail++;
      $display("FAIL parity_one_cycle: par_err=%0b data=%h expected 0 41", par_err, data_out);
    end
    do_write(5'd7, 8'h41, 1'b0);
    do_read(5'd7);
    n_tests++;
    if (data_out !== 8'h41 || par_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clean: data=%h par_err=%0b expected 41 0", data_out, par_err);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_clear();
    test_data_eq_addr();
    test_random_ascii();
    test_collision();
    test_saturation();
    test_busy_midsweep();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synchronous 32x8 memory responder: the target end of the memory bus that the memory testbench and other initiators drive with `read`/`write` strobes. It stores writes, returns registered read data, clears itself after reset, counts accesses and flags protocol violations. It sits directly on the memory interface as the device under test for the memory test sequences.

## Interface

Parameters:
- `AWIDTH`, 5, address width.
- `DWIDTH`, 8, data width.
- `DEPTH`, 32, number of words; must equal 2**AWIDTH.

Ports:
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `read`  input  1  read strobe.
- `write`  input  1  write strobe.
- `addr`  input  AWIDTH  word address.
- `data_in`  input  DWIDTH  write data.
- `data_out`  output  DWIDTH  registered read data.
- `busy`  output  1  high while the post-reset clear sweep runs.
- `rw_err`  output  1  sticky protocol-violation flag.
- `rd_cnt`  output  8  saturating count of executed reads.
- `wr_cnt`  output  8  saturating count of executed writes.
- `par_inject`  input  1  when high with an executed write, store inverted parity (see Configuration).
- `par_err`  output  1  parity mismatch on the read data presented this cycle.

## Operation

- States: `INIT` (clear sweep) and `READY`.
- `rst` high at an edge: state goes to `INIT`, sweep pointer = 0, `busy`=1, `data_out`=0, `rw_err`=0, `rd_cnt`=0, `wr_cnt`=0, `par_err`=0. Applies at any time, including mid-sweep: the sweep restarts at 0.
- `INIT`: each edge with `rst` low writes 0 (with correct parity) to the sweep-pointer word and increments the pointer. The edge that writes word DEPTH-1 moves the state to `READY` and drives `busy`=0.
- `read`/`write` in `INIT`: not executed; `rw_err` set.
- `READY`, `write` only: `mem[addr]` <= `data_in`; `wr_cnt` increments and saturates at 255.
- `READY`, `read` only: `data_out` <= `mem[addr]`; `rd_cnt` increments and saturates at 255.
- `READY`, both strobes high: nothing is executed; memory, `data_out` and the counters hold; `rw_err` set.
- `data_out` holds its last value whenever no read executes.
- `rw_err` clears only on `rst`.
- `addr` is always in range because DEPTH = 2**AWIDTH; there is no wrap logic.

## Timing

- Write latency: memory is updated at the sampling edge. A read of the same address in the next cycle returns the new data.
- Read latency: 1 cycle. Strobe sampled at edge N; `data_out` is valid after edge N and stays stable until the next executed read.
- `par_err` is registered alongside `data_out` and is valid only in the cycle after an executed read. It is 0 in all other cycles.
- `busy` stays high for exactly DEPTH edges after the first edge with `rst` low.
- Counters update at the same edge as the access.

## Configuration

- `MEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit computed from `data_in`, or the inverted bit when `par_inject`=1 during the write.
  - On an executed read, `par_err` = 1 when the recomputed parity differs from the stored bit.
- `MEM_PARITY_EN` undefined:
  - No parity storage.
  - `par_inject` is ignored.
  - `par_err` is tied to 0.
- All other behaviour is identical in both builds.

## Test plan

- Clear after reset: pulse `rst` 1 cycle, wait for `busy`=0 (expected exactly 32 cycles), read addresses 0..31 -> every `data_out` = 8'h00, `rw_err`=0, `rd_cnt`=32.
- Data = address: write `i` to each address 0..31, then read all -> `data_out` = `i` at each address, `wr_cnt`=32.
- Random ASCII data: per address, write a random value drawn 80% from 8'h41–8'h5A and 20% from 8'h61–8'h7A, read back the next cycle -> exact match, no `par_err`.
- Collision: write 8'hA5 to address 3, then assert `read` and `write` with 8'h5A in the same cycle -> `rw_err`=1 and stays set. Later read of address 3 -> 8'hA5. Counters unchanged by the collision cycle.
- Reset mid-sweep and access while busy:
  - Assert `read` during `INIT` -> `rw_err`=1.
  - Assert `rst` at sweep pointer 17 -> `busy` stays high for a full 32 further cycles, and all words read 8'h00 afterwards.
- Parity (build with `MEM_PARITY_EN`): write 8'h41 to address 7 with `par_inject`=1, then read -> `data_out`=8'h41 and `par_err`=1 for one cycle. Rewrite without injection and read -> `par_err`=0. Same sequence without the macro -> `par_err` always 0.
